// File: rtl/seq_comparator.sv
// Bit-serial magnitude comparator: scans captured operands MSB first and stops at the first differing bit.
// Optional two's-complement mode via SEQ_COMPARATOR_SIGNED_EN (inverts the sense of the MSB comparison).
module seq_comparator #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             F1,
    output logic             F2,
    output logic             F3,
    output logic [CW-1:0]    cycles,
    output logic [1:0]       o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MSB  = IW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_cnt;
    logic             r_f1;
    logic             r_f2;
    logic             r_f3;
    logic [CW-1:0]    r_cycles;

    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_a_wins;
    logic [CW-1:0]    w_cnt_next;

    assign w_a_bit    = r_a[r_idx];
    assign w_b_bit    = r_b[r_idx];
    assign w_cnt_next = r_cnt + 1'b1;

    // w_a_wins: when the bits differ, is A the larger operand?
`ifdef SEQ_COMPARATOR_SIGNED_EN
    assign w_a_wins = w_a_bit ^ (r_idx == IDX_MSB);
`else
    assign w_a_wins = w_a_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_f1     <= 1'b0;
            r_f2     <= 1'b0;
            r_f3     <= 1'b0;
            r_cycles <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_idx   <= IDX_MSB;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cnt <= w_cnt_next;
                    if (w_a_bit != w_b_bit) begin
                        r_f1     <= w_a_wins;
                        r_f2     <= 1'b0;
                        r_f3     <= ~w_a_wins;
                        r_cycles <= w_cnt_next;
                        r_state  <= S_DONE;
                    end else if (r_idx == '0) begin
                        r_f1     <= 1'b0;
                        r_f2     <= 1'b1;
                        r_f3     <= 1'b0;
                        r_cycles <= CNT_FULL;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = (r_state == S_RUN) || (r_state == S_DONE);
    assign done        = (r_state == S_DONE);
    assign F1          = r_f1;
    assign F2          = r_f2;
    assign F3          = r_f3;
    assign cycles      = r_cycles;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_comparator.sv
// Randomized and directed bench for seq_comparator; results are predicted from integer arithmetic on the operands.
module tb_seq_comparator;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          busy;
    logic          done;
    logic          f1;
    logic          f2;
    logic          f3;
    logic [CW-1:0] cycles;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // {F1, F2, F3, cycles} for each issued comparison
    logic [CW+2:0] exp_q[$];

    seq_comparator #(.WIDTH(W), .CW(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .A           (a_in),
        .B           (b_in),
        .busy        (busy),
        .done        (done),
        .F1          (f1),
        .F2          (f2),
        .F3          (f3),
        .cycles      (cycles),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference: ordering from integer values, latency from the highest differing bit.
    function automatic logic [CW+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib, diff, k;
        logic g, e, l;
        ia = int'(a);
        ib = int'(b);
`ifdef SEQ_COMPARATOR_SIGNED_EN
        if (a[W-1]) ia = ia - (1 << W);
        if (b[W-1]) ib = ib - (1 << W);
`endif
        diff = int'(a ^ b);
        if (diff == 0) k = W;
        else k = W - ($clog2(diff + 1) - 1);
        g = (ia > ib);
        e = (ia == ib);
        l = (ia < ib);
        return {g, e, l, CW'(k)};
    endfunction

    function automatic int exp_k(input logic [CW+2:0] r);
        return int'(r[CW-1:0]);
    endfunction

    // Runs one comparison; optionally pulses start with A=0xFF mid-run to show it is ignored.
    task automatic do_compare(input logic [W-1:0] a, input logic [W-1:0] b, input bit poke_run);
        logic [CW+2:0] ex;
        int k;
        int busy_cnt;
        ex = model(a, b);
        exp_q.push_back(ex);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        k = 0;
        busy_cnt = busy ? 1 : 0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        while (1) begin
            if (poke_run && k == 1 && !done) begin
                a_in  = '1;
                start = 1'b1;
            end
            @(posedge clk);
            k++;
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) break;
            if (k > W + 2) begin
                check("done_timeout", 32'd0, 32'd1);
                break;
            end
        end
        ex = exp_q.pop_front();
        check("latency_k", k, exp_k(ex));
        check("flags", {29'd0, f1, f2, f3}, {29'd0, ex[CW+2:CW]});
        check("cycles", {28'd0, cycles}, {28'd0, ex[CW-1:0]});
        check("busy_span", busy_cnt, exp_k(ex) + 1);
        @(negedge clk);
        check("done_one_cycle", {30'd0, done, busy}, 32'd0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("result_hold", {25'd0, f1, f2, f3, cycles}, {25'd0, ex});
    endtask

    initial begin
        logic [CW+2:0] ex;
        int last_done;
        int pulses;
        int bad_gap;
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #12;
        check("reset_outputs", {25'd0, busy, done, f1, f2, f3, cycles}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_compare(8'h80, 8'h7F, 1'b0);
        do_compare(8'h5A, 8'h5A, 1'b0);
        do_compare(8'h12, 8'h13, 1'b1);
        do_compare(8'h00, 8'hFF, 1'b0);
        do_compare(8'hFF, 8'hFE, 1'b0);
        for (int i = 0; i < 24; i++) do_compare(W'($urandom), W'($urandom), i[0]);

        // Abort during RUN: outputs clear asynchronously and no done pulse follows.
        @(negedge clk);
        a_in  = 8'h00;
        b_in  = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {25'd0, busy, done, f1, f2, f3, cycles}, 32'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) pulses++;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("no_done_after_abort", pulses, 0);
        do_compare(8'h03, 8'h01, 1'b0);

        // Continuous start: one comparison every k+2 cycles.
        ex = model(8'h40, 8'h00);
        @(negedge clk);
        a_in  = 8'h40;
        b_in  = 8'h00;
        start = 1'b1;
        pulses = 0;
        last_done = -1;
        bad_gap = 0;
        for (int p = 1; p <= 40; p++) begin
            @(negedge clk);
            if (done) begin
                if (last_done >= 0 && p - last_done != exp_k(ex) + 2) bad_gap++;
                last_done = p;
                pulses++;
            end
        end
        start = 1'b0;
        check("b2b_pulses", pulses, 10);
        check("b2b_gaps", bad_gap, 0);
        check("b2b_result", {25'd0, f1, f2, f3, cycles}, {25'd0, ex});
        repeat (6) @(negedge clk);
        check("idle_after_b2b", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
